// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the multi-read-port register file.
//   DW_DEF / DEPTH_DEF / NRD_MAX : default geometry and read-port ceiling.
//   AW_MAX / RA_BUS_W            : widest address and packed read-address bus
//                                  that port_addr() can unpack.
//   port_addr()                  : extracts the address of read port idx from
//                                  a packed bus laid out as [idx*aw +: aw].
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRD_MAX   = 4;
  localparam int AW_MAX    = 16;
  localparam int RA_BUS_W  = NRD_MAX * AW_MAX;

  // The bus is zero-extended to RA_BUS_W by the caller, so one helper covers
  // every legal parameterisation; the caller truncates to its own AW.
  function automatic logic [AW_MAX-1:0] port_addr(input logic [RA_BUS_W-1:0] bus,
                                                  input int idx,
                                                  input int aw);
    logic [RA_BUS_W-1:0] shifted;
    logic [AW_MAX-1:0]   mask;
    shifted = bus >> (idx * aw);
    mask    = '0;
    for (int b = 0; b < AW_MAX; b++) begin
      if (b < aw) mask[b] = 1'b1;
    end
    return shifted[AW_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register pending bits for RAW hazard detection, plus a registered
//   count of how many registers are pending.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     set_en, set_addr  reservation (already qualified: valid, not reg 0)
//     clr_en, clr_addr  retiring write (already qualified)
//     pend              pending vector, one bit per register
//     pend_cnt          popcount of pend, updated on the same edge as pend
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] pend,
  output logic [AW:0]      pend_cnt
);

  logic [DEPTH-1:0] pend_next;
  logic [AW:0]      cnt_next;

  // Set is applied after clear so that a new producer issuing on the same
  // edge the old one retires keeps the register pending. The count is taken
  // from the next-state vector so it lands on the same edge as pend.
  always_comb begin
    pend_next = pend;
    if (clr_en) pend_next[clr_addr] = 1'b0;
    if (set_en) pend_next[set_addr] = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + (AW+1)'(pend_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file: one write port, NRD combinational read ports
//   and a pending scoreboard so issue logic can detect RAW hazards.
//   Parameters: DW data width, DEPTH registers (>= 2), NRD read ports (1..4),
//               ZERO_REG (1: register 0 reads 0, ignores writes, never pends).
//   Ports:
//     clk                       clock, rising edge
//     Reset                     asynchronous active-low reset
//     Wenable, WrtAdd, DIn      write port (writeback stage)
//     RdAdd  [NRD*AW]           packed read addresses, port i at [i*AW +: AW]
//     Data   [NRD*DW]           packed read data,      port i at [i*DW +: DW]
//     Busy   [NRD]              port i addresses a pending register
//     Reserve, ResAdd           mark a register pending (producer issued)
//     PendCnt [AW+1]            number of pending registers
//   Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to
//   any read port addressing the written register (and report it not busy).
module regfile_mp import regfile_pkg::*; #(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Wenable,
  input  logic [AW-1:0]     WrtAdd,
  input  logic [DW-1:0]     DIn,
  input  logic [NRD*AW-1:0] RdAdd,
  output logic [NRD*DW-1:0] Data,
  output logic [NRD-1:0]    Busy,
  input  logic              Reserve,
  input  logic [AW-1:0]     ResAdd,
  output logic [AW:0]       PendCnt
);

  logic [DW-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]    pend;
  logic [RA_BUS_W-1:0] rd_bus;
  logic                wr_ok;
  logic                res_ok;

  // An address is usable when it names a real register and is not the
  // hard-wired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (32'(a) < DEPTH);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  assign rd_bus = RA_BUS_W'(RdAdd);
  assign wr_ok  = Wenable && addr_ok(WrtAdd);
  assign res_ok = Reserve && addr_ok(ResAdd);

  // Storage: clears asynchronously so reads drop to zero the moment reset
  // asserts; writes that coincide with reset are lost.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wr_ok) begin
      mem[WrtAdd] <= DIn;
    end
  end

  regfile_scoreboard #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (Reset),
    .set_en  (res_ok),
    .set_addr(ResAdd),
    .clr_en  (wr_ok),
    .clr_addr(WrtAdd),
    .pend    (pend),
    .pend_cnt(PendCnt)
  );

  // Read muxing. Invalid addresses read 0 and never report busy. With the
  // bypass built in, a matching in-flight write overrides both data and busy,
  // even when a reservation to the same register lands on the same edge; the
  // bypass is gated by reset so outputs stay zero while reset is asserted.
  always_comb begin
    Data = '0;
    Busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = AW'(port_addr(rd_bus, i, AW));
      if (addr_ok(a)) begin
        Data[i*DW +: DW] = mem[a];
        Busy[i]          = pend[a];
      end
`ifdef REGFILE_BYPASS_EN
      if (Reset && wr_ok && (WrtAdd == a)) begin
        Data[i*DW +: DW] = DIn;
        Busy[i]          = 1'b0;
      end
`endif
    end
  end

endmodule
